// File: rtl/shift_cmd_sequencer_if.sv
// Command handshake between a producer and the shift command sequencer.
// A command is {cmd_dir, cmd_cnt}. It is transferred on a rising edge
// where cmd_valid and cmd_ready are both high.
interface shift_cmd_sequencer_if #(
  parameter int CNT_W = 3
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_dir;
  logic [CNT_W-1:0] cmd_cnt;

  modport master (output cmd_valid, output cmd_dir, output cmd_cnt, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_dir, input cmd_cnt, output cmd_ready);
endinterface

// File: rtl/shift_cmd_sequencer.sv
// Shift command sequencer.
// Queued {dir, cnt} commands are replayed as single-cycle shift_left or
// shift_right pulses. PULSE_GAP idle cycles separate the pulses of one
// command, and a done strobe marks the end of each command. The abort input
// flushes the queue and cancels the command in progress.
module shift_cmd_sequencer #(
  parameter int CNT_W     = 3,
  parameter int DEPTH     = 4,
  parameter int PULSE_GAP = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  shift_cmd_sequencer_if.slave   cmd,
  input  logic                   abort,
  output logic                   shift_left,
  output logic                   shift_right,
  output logic                   busy,
  output logic                   done,
  output logic [$clog2(DEPTH):0] fifo_level
);
  localparam int AW = $clog2(DEPTH);
  // The gap counter keeps at least one bit so that PULSE_GAP of 0 or 1 still elaborates.
  localparam int GW = (PULSE_GAP > 1) ? $clog2(PULSE_GAP + 1) : 1;

  typedef struct packed {
    logic             dir;
    logic [CNT_W-1:0] cnt;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

  cmd_t             mem [DEPTH];
  cmd_t             head;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      level;
  logic             full, empty, push, pop;
  state_t           state, state_nx;
  logic             dir, dir_nx;
  logic [CNT_W-1:0] rem, rem_nx;
  logic [GW-1:0]    gap, gap_nx;

  assign full          = (level == (AW+1)'(DEPTH));
  assign empty         = (level == '0);
  // Readiness uses only the current fill level. A pop in the same cycle does not free a slot.
  assign cmd.cmd_ready = !full && !abort && !rst;
  assign push          = cmd.cmd_valid && cmd.cmd_ready;
  assign pop           = (state == IDLE) && !empty && !abort;
  assign head          = mem[rd_ptr];

  // Update the FIFO pointers and occupancy. Reset and abort both leave the FIFO empty.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  // Write accepted commands into FIFO storage. The storage needs no reset because the pointers guard it.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{dir: cmd.cmd_dir, cnt: cmd.cmd_cnt};
  end

  // Register the FSM state and the per-command counters.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state <= IDLE;
      dir   <= 1'b0;
      rem   <= '0;
      gap   <= '0;
    end else begin
      state <= state_nx;
      dir   <= dir_nx;
      rem   <= rem_nx;
      gap   <= gap_nx;
    end
  end

  // Next-state logic: pop in IDLE, pulse in SHIFT, wait in GAP, then strobe DONE.
  always_comb begin
    state_nx = state;
    dir_nx   = dir;
    rem_nx   = rem;
    gap_nx   = gap;
    unique case (state)
      IDLE: begin
        if (pop) begin
          dir_nx   = head.dir;
          rem_nx   = head.cnt;
          state_nx = (head.cnt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (rem == CNT_W'(1)) begin
          state_nx = DONE;
        end else begin
          rem_nx = rem - CNT_W'(1);
          if (PULSE_GAP == 0) begin
            state_nx = SHIFT;
          end else begin
            state_nx = GAP;
            gap_nx   = GW'(PULSE_GAP);
          end
        end
      end
      GAP: begin
        if (gap == GW'(1)) state_nx = SHIFT;
        else               gap_nx   = gap - GW'(1);
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign shift_left  = (state == SHIFT) && !dir;
  assign shift_right = (state == SHIFT) &&  dir;
  assign done        = (state == DONE);
  assign busy        = (state != IDLE) || !empty;
  assign fifo_level  = level;
endmodule

// File: tb/tb_shift_cmd_sequencer.sv
// Bench for shift_cmd_sequencer. Two instances are driven with identical
// stimulus: dut0 uses PULSE_GAP=1 and dut1 uses PULSE_GAP=0. A queue/timing
// reference model checks every output on every cycle. Directed tables and
// sequences cover the specific corner cases. A 4-bit downstream register is
// fed by each instance's pulses.
module tb_shift_cmd_sequencer;
  localparam int CNT_W = 3;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1, abort = 1'b0, valid = 1'b0, dir = 1'b0;
  logic [CNT_W-1:0] cnt = '0;
  always #5 clk = ~clk;

  shift_cmd_sequencer_if #(.CNT_W(CNT_W)) ifc0 ();
  shift_cmd_sequencer_if #(.CNT_W(CNT_W)) ifc1 ();
  assign ifc0.cmd_valid = valid;
  assign ifc0.cmd_dir   = dir;
  assign ifc0.cmd_cnt   = cnt;
  assign ifc1.cmd_valid = valid;
  assign ifc1.cmd_dir   = dir;
  assign ifc1.cmd_cnt   = cnt;

  logic [1:0]    sl, srt, dn, bz;
  logic [LW-1:0] lvl0, lvl1;

  shift_cmd_sequencer #(.CNT_W(CNT_W), .DEPTH(DEPTH), .PULSE_GAP(1)) dut0 (
    .clk(clk), .rst(rst), .cmd(ifc0), .abort(abort),
    .shift_left(sl[0]), .shift_right(srt[0]), .busy(bz[0]), .done(dn[0]), .fifo_level(lvl0));
  shift_cmd_sequencer #(.CNT_W(CNT_W), .DEPTH(DEPTH), .PULSE_GAP(0)) dut1 (
    .clk(clk), .rst(rst), .cmd(ifc1), .abort(abort),
    .shift_left(sl[1]), .shift_right(srt[1]), .busy(bz[1]), .done(dn[1]), .fifo_level(lvl1));

  int checks = 0, errors = 0, cyc = 0;
  bit armed = 0;

  // Reference model state, per instance: a circular command queue plus the active command.
  logic       mdir [2][DEPTH];
  int         mcnt [2][DEPTH];
  int         mhead[2], msize[2], tm[2], acnt[2];
  bit         act[2], adir[2];
  logic [3:0] sr_reg[2];
  logic       pl[2], pr[2];

  typedef struct {
    logic             v;
    logic             dr;
    logic [CNT_W-1:0] c;
    logic [7:0]       exp;  // {ready, left, right, done, busy, level[2:0]} of dut0
    logic [3:0]       sr;
  } vec_t;
  vec_t tbl[13];

  function automatic logic [7:0] dut_vec(input int d);
    if (d == 0) return {ifc0.cmd_ready, sl[0], srt[0], dn[0], bz[0], lvl0};
    return {ifc1.cmd_ready, sl[1], srt[1], dn[1], bz[1], lvl1};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // A command of cnt pulses with gap g pulses at elapsed cycles 1, 1+(g+1), ... and ends with done.
  function automatic int end_time(input int c, input int g);
    return (c == 0) ? 1 : (c - 1) * (g + 1) + 2;
  endfunction

  task automatic model_check();
    int g, pe;
    logic l, r, de, rdy;
    logic [7:0] exp, got;
    for (int d = 0; d < 2; d++) begin
      g  = (d == 0) ? 1 : 0;
      pe = end_time(acnt[d], g);
      l = 1'b0; r = 1'b0; de = 1'b0;
      if (act[d]) begin
        if (acnt[d] > 0 && tm[d] < pe && ((tm[d] - 1) % (g + 1)) == 0) begin
          if (adir[d]) r = 1'b1; else l = 1'b1;
        end
        if (tm[d] == pe) de = 1'b1;
      end
      rdy = !rst && !abort && (msize[d] < DEPTH);
      exp = {rdy, l, r, de, (act[d] || msize[d] > 0), 3'(msize[d])};
      got = dut_vec(d);
      chk($sformatf("model dut%0d", d), got, exp);
      pl[d] = got[6];
      pr[d] = got[5];
    end
  endtask

  task automatic model_step();
    int  pe;
    bit  do_push, do_pop;
    for (int d = 0; d < 2; d++) begin
      if (pl[d])      sr_reg[d] = {sr_reg[d][2:0], 1'b0};
      else if (pr[d]) sr_reg[d] = {1'b0, sr_reg[d][3:1]};
      pl[d] = 1'b0;
      pr[d] = 1'b0;
      if (rst || abort) begin
        act[d] = 0; msize[d] = 0; mhead[d] = 0;
      end else begin
        pe      = end_time(acnt[d], (d == 0) ? 1 : 0);
        do_push = valid && (msize[d] < DEPTH);
        do_pop  = !act[d] && (msize[d] > 0);
        if (act[d]) begin
          if (tm[d] == pe) act[d] = 0; else tm[d]++;
        end
        if (do_pop) begin
          act[d]  = 1; tm[d] = 1;
          adir[d] = mdir[d][mhead[d]];
          acnt[d] = mcnt[d][mhead[d]];
          mhead[d] = (mhead[d] + 1) % DEPTH;
          msize[d]--;
        end
        if (do_push) begin
          mdir[d][(mhead[d] + msize[d]) % DEPTH] = dir;
          mcnt[d][(mhead[d] + msize[d]) % DEPTH] = int'(cnt);
          msize[d]++;
        end
      end
    end
  endtask

  task automatic tick();
    #1;
    if (armed) model_check();
    @(posedge clk);
    model_step();
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while ((act[0] || act[1] || msize[0] > 0 || msize[1] > 0) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) chk("drain_timeout", 1, 0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      mhead[d] = 0; msize[d] = 0; tm[d] = 0; acnt[d] = 0;
      act[d] = 0; adir[d] = 0; sr_reg[d] = 4'b0; pl[d] = 0; pr[d] = 0;
    end
    // Test 2 (cnt=3 left, gap 1) followed by test 3 (cnt=0), as seen on dut0.
    tbl[0]  = '{1'b1, 1'b0, 3'd3, 8'b1_0_0_0_0_000, 4'b1010};
    tbl[1]  = '{1'b0, 1'b0, 3'd0, 8'b1_0_0_0_1_001, 4'b1010};
    tbl[2]  = '{1'b0, 1'b0, 3'd0, 8'b1_1_0_0_1_000, 4'b1010};
    tbl[3]  = '{1'b0, 1'b0, 3'd0, 8'b1_0_0_0_1_000, 4'b0100};
    tbl[4]  = '{1'b0, 1'b0, 3'd0, 8'b1_1_0_0_1_000, 4'b0100};
    tbl[5]  = '{1'b0, 1'b0, 3'd0, 8'b1_0_0_0_1_000, 4'b1000};
    tbl[6]  = '{1'b0, 1'b0, 3'd0, 8'b1_1_0_0_1_000, 4'b1000};
    tbl[7]  = '{1'b0, 1'b0, 3'd0, 8'b1_0_0_1_1_000, 4'b0000};
    tbl[8]  = '{1'b0, 1'b0, 3'd0, 8'b1_0_0_0_0_000, 4'b0000};
    tbl[9]  = '{1'b1, 1'b0, 3'd0, 8'b1_0_0_0_0_000, 4'b0000};
    tbl[10] = '{1'b0, 1'b0, 3'd0, 8'b1_0_0_0_1_001, 4'b0000};
    tbl[11] = '{1'b0, 1'b0, 3'd0, 8'b1_0_0_1_1_000, 4'b0000};
    tbl[12] = '{1'b0, 1'b0, 3'd0, 8'b1_0_0_0_0_000, 4'b0000};

    // Test 1: reset held for 3 cycles.
    @(negedge clk);
    tick();
    armed = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("rst_out0", dut_vec(0), 8'h00);
      chk("rst_out1", dut_vec(1), 8'h00);
      tick();
    end
    rst = 1'b0;
    #1;
    chk("post_rst_ready_busy0", {ifc0.cmd_ready, bz[0]}, 2'b10);
    chk("post_rst_ready_busy1", {ifc1.cmd_ready, bz[1]}, 2'b10);
    tick();

    // Tests 2 and 3 from the vector table.
    sr_reg[0] = 4'b1010;
    for (int i = 0; i < 13; i++) begin
      valid = tbl[i].v; dir = tbl[i].dr; cnt = tbl[i].c;
      #1;
      chk($sformatf("tbl%0d_out", i), dut_vec(0), tbl[i].exp);
      chk($sformatf("tbl%0d_reg", i), sr_reg[0], tbl[i].sr);
      tick();
    end
    drain();

    // Test 4: five back-to-back pushes while a long command runs.
    valid = 1'b1; dir = 1'b0; cnt = 3'd7;
    tick();
    valid = 1'b0;
    tick(); tick();
    for (int k = 0; k < 5; k++) begin
      logic [3:0] c4;
      c4 = {1'b0, 3'(k * 3 + 2)};
      valid = 1'b1; dir = k[0]; cnt = c4[2:0];
      if (k == 4) begin
        #1;
        chk("t4_full_ready0", ifc0.cmd_ready, 1'b0);
        chk("t4_full_ready1", ifc1.cmd_ready, 1'b0);
        chk("t4_level0", lvl0, 3'd4);
        chk("t4_level1", lvl1, 3'd4);
      end
      tick();
    end
    valid = 1'b0;
    drain();

    // Test 5: abort after the first pulse of a dir=1, cnt=5 command with another command queued.
    valid = 1'b1; dir = 1'b1; cnt = 3'd5;
    tick();
    dir = 1'b0; cnt = 3'd2;
    tick();
    valid = 1'b0;
    tick();
    abort = 1'b1; valid = 1'b1; dir = 1'b1; cnt = 3'd3;
    #1;
    chk("t5_ready_in_abort", ifc0.cmd_ready, 1'b0);
    tick();
    abort = 1'b0; valid = 1'b0;
    #1;
    chk("t5_after0", dut_vec(0), 8'b1_0_0_0_0_000);
    chk("t5_after1", dut_vec(1), 8'b1_0_0_0_0_000);
    for (int i = 0; i < 6; i++) tick();

    // Test 6: dir=1, cnt=4 with no gap on dut1 gives four consecutive right shifts.
    sr_reg[1] = 4'b1010;
    valid = 1'b1; dir = 1'b1; cnt = 3'd4;
    tick();
    valid = 1'b0;
    tick(); tick(); tick();
    #1;
    chk("t6_reg_mid", sr_reg[1], 4'b0010);
    tick(); tick();
    #1;
    chk("t6_done", dn[1], 1'b1);
    chk("t6_reg_end", sr_reg[1], 4'b0000);
    drain();

    // Random traffic with occasional abort and reset.
    for (int i = 0; i < 500; i++) begin
      valid = 1'($urandom_range(0, 1));
      dir   = 1'($urandom_range(0, 1));
      cnt   = 3'($urandom_range(0, 7));
      abort = ($urandom_range(0, 31) == 0);
      rst   = ($urandom_range(0, 99) == 0);
      tick();
    end
    valid = 1'b0; abort = 1'b0; rst = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
